ascii_token_loader: RTL and testbench

- Parametrised successor of the UART decimal input stage. Consumes a byte stream of ASCII decimal tokens and writes each completed number to memory at sequential addresses.
- Adds the following over the previous stage:
  - configurable data/address width;
  - per-session element count with completion flag;
  - overflow detection;
  - collapsing of repeated delimiters;
  - error recovery that discards only the bad token.
- Sits between the UART receiver (byte source) and the matrix/operand storage write port. It is enabled by the top-level FSM.

---
 rtl/token_pkg.sv | 32 +++
 rtl/dec_accumulator.sv | 22 ++
 rtl/ascii_token_loader.sv | 166 ++++++++++++++++
 tb/tb_ascii_token_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/token_pkg.sv
// Shared definitions for the ASCII decimal token loader: character codes,
// error codes and the loader state encoding.
package token_pkg;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_MINUS = 8'h2D;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_FULL     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SKIP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASC_0) && (b <= ASC_9);
  endfunction

  function automatic logic is_delim(input logic [7:0] b);
    return (b == ASC_SPACE) || (b == ASC_CR) || (b == ASC_LF);
  endfunction

endpackage

// File: rtl/dec_accumulator.sv
// Combinational decimal step: nxt = acc*10 + digit, evaluated 4 bits wider
// than DATA_W so the overflow compare against limit is exact.
module dec_accumulator #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [3:0]        digit,
  input  logic [DATA_W-1:0] limit,
  output logic [DATA_W-1:0] nxt,
  output logic              ovf
);

  logic [DATA_W+3:0] acc_wide;
  logic [DATA_W+3:0] sum_wide;

  assign acc_wide = {4'd0, acc};
  // acc*10 as (acc<<3)+(acc<<1); max (2^DATA_W-1)*10+9 fits in DATA_W+4 bits
  assign sum_wide = (acc_wide << 3) + (acc_wide << 1) + {{DATA_W{1'b0}}, digit};
  assign nxt      = sum_wide[DATA_W-1:0];
  assign ovf      = sum_wide > {4'd0, limit};

endmodule

// File: rtl/ascii_token_loader.sv
// Parses a stream of ASCII decimal tokens and writes each number to storage
// at sequential addresses. Signed tokens need ASCII_TOKEN_LOADER_NEG_EN.
module ascii_token_loader
  import token_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_DIGITS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W:0]   cfg_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err_flag,
  output logic [1:0]        err_code,
  output state_t            dbg_state
);

  localparam int NDIG_W = $clog2(MAX_DIGITS + 1);
  localparam logic [NDIG_W-1:0] NDIG_MAX   = NDIG_W'(MAX_DIGITS);
  localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [NDIG_W-1:0] ndig;
  logic [ADDR_W:0]   target;
  logic [DATA_W-1:0] acc_nxt;
  logic              acc_ovf;
  logic [DATA_W-1:0] limit;
  logic [ADDR_W:0]   cnt_inc;
  logic              reach_end;
  logic              neg;

  assign cnt_inc   = count + 1'b1;
  assign reach_end = ((target != '0) && (cnt_inc == target)) || (cnt_inc == FULL_COUNT);
  assign dbg_state = state;

`ifdef ASCII_TOKEN_LOADER_NEG_EN
  // Negative tokens may reach one further in magnitude than positive ones
  assign limit = neg ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
  assign limit = '1;
`endif

  dec_accumulator #(.DATA_W(DATA_W)) u_dec (
    .acc   (acc),
    .digit (rx_data[3:0]),
    .limit (limit),
    .nxt   (acc_nxt),
    .ovf   (acc_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      ndig     <= '0;
      count    <= '0;
      target   <= '0;
      neg      <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= BASE;
      wr_data  <= '0;
      done     <= 1'b0;
      err_flag <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      wr_en    <= 1'b0;
      err_flag <= 1'b0;
      if (!en) begin
        state <= ST_IDLE;
        acc   <= '0;
        ndig  <= '0;
        count <= '0;
        neg   <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            target   <= cfg_count;
            count    <= '0;
            wr_addr  <= BASE;
            err_code <= ERR_NONE;
            acc      <= '0;
            ndig     <= '0;
            neg      <= 1'b0;
            state    <= ST_ACCUM;
          end
          ST_ACCUM: begin
            if (rx_valid) begin
              if (is_digit(rx_data)) begin
                if (acc_ovf || (ndig == NDIG_MAX)) begin
                  err_code <= ERR_OVERFLOW;
                  err_flag <= 1'b1;
                  acc      <= '0;
                  ndig     <= '0;
                  neg      <= 1'b0;
                  state    <= ST_SKIP;
                end else begin
                  acc  <= acc_nxt;
                  ndig <= ndig + 1'b1;
                end
              end else if (is_delim(rx_data)) begin
                if (ndig != '0) begin
                  wr_en   <= 1'b1;
                  wr_data <= neg ? (~acc + 1'b1) : acc;
                  wr_addr <= BASE + count[ADDR_W-1:0];
                  count   <= cnt_inc;
                  acc     <= '0;
                  ndig    <= '0;
                  neg     <= 1'b0;
                  if (reach_end) begin
                    done  <= 1'b1;
                    state <= ST_DONE;
                  end
                end else if (neg) begin
                  // A sign with no digits is a malformed token
                  err_code <= ERR_BAD_CHAR;
                  err_flag <= 1'b1;
                  neg      <= 1'b0;
                end
`ifdef ASCII_TOKEN_LOADER_NEG_EN
              end else if ((rx_data == ASC_MINUS) && (ndig == '0) && !neg) begin
                neg <= 1'b1;
`endif
              end else begin
                err_code <= ERR_BAD_CHAR;
                err_flag <= 1'b1;
                acc      <= '0;
                ndig     <= '0;
                neg      <= 1'b0;
                state    <= ST_SKIP;
              end
            end
          end
          ST_SKIP: begin
            if (rx_valid && is_delim(rx_data)) state <= ST_ACCUM;
          end
          ST_DONE: begin
            // Once storage is full, a further complete numeric token is reported
            if (rx_valid && (count == FULL_COUNT)) begin
              if (is_digit(rx_data)) begin
                ndig <= NDIG_W'(1);
              end else if (is_delim(rx_data) && (ndig != '0)) begin
                err_code <= ERR_FULL;
                err_flag <= 1'b1;
                ndig     <= '0;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascii_token_loader.sv
// Directed bench for ascii_token_loader: a wide instance (32/8) and a narrow
// one (8/2) with scoreboards for writes and error pulses.
module tb_ascii_token_loader;
  import token_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Valid/ready: rx_valid is a one-cycle strobe with no back-pressure; the
  // loader accepts a byte on every cycle rx_valid is high.
  logic        en_a = 1'b0, rx_valid_a = 1'b0;
  logic [8:0]  cfg_a = '0;
  logic [7:0]  rx_data_a = '0;
  logic        wr_en_a, done_a, err_flag_a;
  logic [7:0]  wr_addr_a;
  logic [31:0] wr_data_a;
  logic [8:0]  count_a;
  logic [1:0]  err_code_a;
  state_t      state_a;

  logic        en_b = 1'b0, rx_valid_b = 1'b0;
  logic [2:0]  cfg_b = '0;
  logic [7:0]  rx_data_b = '0;
  logic        wr_en_b, done_b, err_flag_b;
  logic [1:0]  wr_addr_b;
  logic [7:0]  wr_data_b;
  logic [2:0]  count_b;
  logic [1:0]  err_code_b;
  state_t      state_b;

  logic [47:0] exp_q_a[$], exp_q_b[$];
  logic [1:0]  exp_err_a[$], exp_err_b[$];
  int n_checks = 0;
  int n_fail   = 0;

  ascii_token_loader #(.DATA_W(32), .ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .cfg_count(cfg_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .count(count_a), .done(done_a), .err_flag(err_flag_a), .err_code(err_code_a),
    .dbg_state(state_a)
  );

  ascii_token_loader #(.DATA_W(8), .ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .cfg_count(cfg_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .count(count_b), .done(done_b), .err_flag(err_flag_b), .err_code(err_code_b),
    .dbg_state(state_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mk(input logic d, input logic [7:0] addr, input logic [31:0] data);
    return {7'd0, d, addr, data};
  endfunction

  // Write and error scoreboards
  always @(negedge clk) begin
    if (wr_en_a) begin
      if (exp_q_a.size() == 0) check_eq("a_unexp_wr", mk(done_a, wr_addr_a, wr_data_a), '1);
      else check_eq("a_wr", mk(done_a, wr_addr_a, wr_data_a), exp_q_a.pop_front());
    end
    if (err_flag_a) begin
      if (exp_err_a.size() == 0) check_eq("a_unexp_err", 48'(err_code_a), 48'hdead);
      else check_eq("a_err", 48'(err_code_a), 48'(exp_err_a.pop_front()));
    end
    if (wr_en_b) begin
      if (exp_q_b.size() == 0) check_eq("b_unexp_wr", mk(done_b, 8'(wr_addr_b), 32'(wr_data_b)), '1);
      else check_eq("b_wr", mk(done_b, 8'(wr_addr_b), 32'(wr_data_b)), exp_q_b.pop_front());
    end
    if (err_flag_b) begin
      if (exp_err_b.size() == 0) check_eq("b_unexp_err", 48'(err_code_b), 48'hdead);
      else check_eq("b_err", 48'(err_code_b), 48'(exp_err_b.pop_front()));
    end
  end

  // Drivers: called at 1 time unit after a rising edge, return likewise
  task automatic start_a(input logic [8:0] c);
    cfg_a = c; en_a = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic start_b(input logic [2:0] c);
    cfg_b = c; en_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_a(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx_data_a = s[i]; rx_valid_a = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid_a = 1'b0;
  endtask

  task automatic send_b(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx_data_b = s[i]; rx_valid_b = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid_b = 1'b0;
  endtask

  task automatic stop_a();
    en_a = 1'b0;
    @(posedge clk); #1;
    check_eq("a_stop_count", 48'(count_a), 48'd0);
    check_eq("a_stop_done", 48'(done_a), 48'd0);
  endtask

  task automatic stop_b();
    en_b = 1'b0;
    @(posedge clk); #1;
    check_eq("b_stop_count", 48'(count_b), 48'd0);
    check_eq("b_stop_state", 48'(state_b), 48'(ST_IDLE));
  endtask

  task automatic drain(input string tag);
    repeat (2) @(negedge clk);
    check_eq({tag, "_wr_left"}, 48'(exp_q_a.size() + exp_q_b.size()), 48'd0);
    check_eq({tag, "_err_left"}, 48'(exp_err_a.size() + exp_err_b.size()), 48'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_state", 48'(state_a), 48'(ST_IDLE));
    check_eq("rst_addr", 48'(wr_addr_a), 48'd0);
    check_eq("rst_outs", {wr_en_a, done_a, err_flag_a, err_code_a, count_a}, '0);
    @(posedge clk); #1;

    // Three-element session with a CR/LF pair between tokens
    exp_q_a.push_back(mk(0, 0, 12));
    exp_q_a.push_back(mk(0, 1, 7));
    exp_q_a.push_back(mk(1, 2, 4095));
    start_a(9'd3);
    send_a("12 7\r\n4095 ");
    drain("t1");
    check_eq("t1_count", 48'(count_a), 48'd3);
    check_eq("t1_done", 48'(done_a), 48'd1);
    check_eq("t1_state", 48'(state_a), 48'(ST_DONE));
    check_eq("t1_errc", 48'(err_code_a), 48'd0);
    stop_a();

    // Bad character discards only its own token
    exp_q_a.push_back(mk(0, 0, 5));
    exp_q_a.push_back(mk(1, 1, 8));
    exp_err_a.push_back(ERR_BAD_CHAR);
    start_a(9'd2);
    send_a("5 x9 8 ");
    drain("t2");
    check_eq("t2_errc", 48'(err_code_a), 48'(ERR_BAD_CHAR));
    check_eq("t2_done", 48'(done_a), 48'd1);
    stop_a();

    // Narrow data: the largest value fits, one more overflows
    exp_err_b.push_back(ERR_OVERFLOW);
    start_b(3'd0);
`ifdef ASCII_TOKEN_LOADER_NEG_EN
    exp_q_b.push_back(mk(0, 0, 127));
    send_b("127 128 ");
`else
    exp_q_b.push_back(mk(0, 0, 255));
    send_b("255 256 ");
`endif
    drain("t3");
    check_eq("t3_count", 48'(count_b), 48'd1);
    check_eq("t3_errc", 48'(err_code_b), 48'(ERR_OVERFLOW));
    stop_b();

    // Abort with a partial token, then a fresh session; checks write latency
    start_a(9'd0);
    send_a("12");
    stop_a();
    exp_q_a.push_back(mk(0, 0, 3));
    start_a(9'd0);
    send_a("3 ");
    check_eq("t4_latency", 48'(wr_en_a), 48'd1);
    drain("t4");
    check_eq("t4_count", 48'(count_a), 48'd1);
    stop_a();

    // Unlimited count on 4-entry storage: fills, then rejects the fifth token
    exp_q_b.push_back(mk(0, 0, 1));
    exp_q_b.push_back(mk(0, 1, 2));
    exp_q_b.push_back(mk(0, 2, 3));
    exp_q_b.push_back(mk(1, 3, 4));
    exp_err_b.push_back(ERR_FULL);
    start_b(3'd0);
    send_b("1  2\r\n3 4 5 ");
    drain("t5");
    check_eq("t5_count", 48'(count_b), 48'd4);
    check_eq("t5_done", 48'(done_b), 48'd1);
    check_eq("t5_errc", 48'(err_code_b), 48'(ERR_FULL));
    stop_b();

    // Minus sign handling
    start_b(3'd0);
`ifdef ASCII_TOKEN_LOADER_NEG_EN
    exp_q_b.push_back(mk(0, 0, 32'h80));
    exp_err_b.push_back(ERR_OVERFLOW);
    exp_err_b.push_back(ERR_BAD_CHAR);
    send_b("-128 -129 - ");
`else
    exp_q_b.push_back(mk(0, 0, 7));
    exp_err_b.push_back(ERR_BAD_CHAR);
    send_b("-5 7 ");
`endif
    drain("t6");
    check_eq("t6_count", 48'(count_b), 48'd1);
    check_eq("t6_errc", 48'(err_code_b), 48'(ERR_BAD_CHAR));
    stop_b();

    // Full-width limit and digit-count limit
    exp_err_a.push_back(ERR_OVERFLOW);
    exp_err_a.push_back(ERR_OVERFLOW);
    start_a(9'd0);
`ifdef ASCII_TOKEN_LOADER_NEG_EN
    exp_q_a.push_back(mk(0, 0, 32'h7FFFFFFF));
    send_a("2147483647 2147483648 00000000001 ");
`else
    exp_q_a.push_back(mk(0, 0, 32'hFFFFFFFF));
    send_a("4294967295 4294967296 00000000001 ");
`endif
    drain("t7");
    check_eq("t7_count", 48'(count_a), 48'd1);
    check_eq("t7_state", 48'(state_a), 48'(ST_ACCUM));
    stop_a();

    // Reset in the middle of a token clears everything
    start_a(9'd0);
    send_a("99");
    rst = 1'b1;
    @(negedge clk);
    check_eq("t8_rst_count", 48'(count_a), 48'd0);
    check_eq("t8_rst_state", 48'(state_a), 48'(ST_IDLE));
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    exp_q_a.push_back(mk(0, 0, 4));
    send_a("4 ");
    drain("t8");
    check_eq("t8_count", 48'(count_a), 48'd1);
    stop_a();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
